// File: rtl/dma_priority_arbiter_if.sv
// Request/grant bundle between the DMA register file, the timing FSM and the arbiter.
// The master side drives requests and controls; the slave side (the arbiter) drives the bus handshake.
interface dma_priority_arbiter_if;
  logic [3:0] dreq;
  logic       hlda;
  logic       eopN;
  logic       cycleDone;
  logic [7:0] commandReg;
  logic [3:0] maskReg;
  logic [3:0] requestReg;
  logic [7:0] modeSel;
  logic       hrq;
  logic [3:0] dack;
  logic [3:0] validDreq;
  logic [1:0] activeChannel;
  logic [3:0] clrReq;

  modport master (
    output dreq, hlda, eopN, cycleDone, commandReg, maskReg, requestReg, modeSel,
    input  hrq, dack, validDreq, activeChannel, clrReq
  );

  modport slave (
    input  dreq, hlda, eopN, cycleDone, commandReg, maskReg, requestReg, modeSel,
    output hrq, dack, validDreq, activeChannel, clrReq
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// 8237A-style channel arbiter: qualifies DREQ, requests the bus and grants one channel per hold cycle.
// Optional macro DMA_ROTATE_PRIORITY_EN enables rotating priority selected by commandReg[4].
module dma_priority_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dma_priority_arbiter_if.slave   bus_io
);

  typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   eff_q, eff_d;
  logic [NUM_CH-1:0]   grantVec_q, grantVec_d;
  logic [NUM_CH-1:0]   clrReq_q, clrReq_d;
  logic [1:0]          winner_q, winner_d;
  logic                hrq_q, hrq_d;
  logic [1:0]          pri;
  logic [1:0]          pick;
  logic [1:0]          idx;
  logic                found;
  logic [1:0]          winMode;
  logic                eopExit;
  logic                leaveGrant;

  assign eff_d = ((bus_io.dreq ^ {NUM_CH{bus_io.commandReg[6]}}) & ~bus_io.maskReg)
                 | bus_io.requestReg;
  assign winMode    = bus_io.modeSel[{winner_q, 1'b0} +: 2];
  assign leaveGrant = (state_q == GRANT) && (state_d != GRANT);

`ifdef DMA_ROTATE_PRIORITY_EN
  logic [1:0] pri_q, pri_d;
  logic       unusedCmd;

  assign pri       = pri_q;
  assign unusedCmd = ^{bus_io.commandReg[5], bus_io.commandReg[3], bus_io.commandReg[1:0]};

  // The serviced channel drops to lowest priority; clearing commandReg[4] returns to fixed order.
  always_comb begin
    pri_d = pri_q;
    if (!bus_io.commandReg[4]) begin
      pri_d = 2'd0;
    end else if (leaveGrant) begin
      pri_d = winner_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q <= 2'd0;
    end else begin
      pri_q <= pri_d;
    end
  end
`else
  logic unusedCmd;

  assign pri       = 2'd0;
  assign unusedCmd = ^{bus_io.commandReg[5:3], bus_io.commandReg[1:0]};
`endif

  // Search order starts at the priority pointer and wraps modulo four.
  always_comb begin
    pick  = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = pri + 2'(i);
      if (!found && eff_q[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      eff_q      <= '0;
      grantVec_q <= '0;
      clrReq_q   <= '0;
      winner_q   <= 2'd0;
      hrq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      eff_q      <= eff_d;
      grantVec_q <= grantVec_d;
      clrReq_q   <= clrReq_d;
      winner_q   <= winner_d;
      hrq_q      <= hrq_d;
    end
  end

  // Losing HLDA mid-grant is a protocol error and outranks EOP, so no request bit is cleared.
  always_comb begin
    state_d = state_q;
    eopExit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|eff_q && !bus_io.commandReg[2]) state_d = REQ;
      end
      REQ: begin
        if (bus_io.commandReg[2] || eff_q == '0) state_d = RELEASE;
        else if (bus_io.hlda)                    state_d = GRANT;
      end
      GRANT: begin
        if (!bus_io.hlda) begin
          state_d = RELEASE;
        end else if (!bus_io.eopN) begin
          state_d = RELEASE;
          eopExit = 1'b1;
        end else begin
          unique case (winMode)
            2'b00:   if (bus_io.cycleDone && !eff_q[winner_q]) state_d = RELEASE;
            2'b01:   if (bus_io.cycleDone)                     state_d = RELEASE;
            2'b10:   state_d = GRANT;
            default: if (!eff_q[winner_q])                     state_d = RELEASE;
          endcase
        end
      end
      RELEASE: begin
        if (!bus_io.hlda) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hrq_d      = (state_d == REQ) || (state_d == GRANT);
    winner_d   = winner_q;
    grantVec_d = '0;
    clrReq_d   = '0;
    if (state_q == REQ && state_d == GRANT) winner_d = pick;
    if (state_d == GRANT) grantVec_d = NUM_CH'(1) << winner_d;
    if (eopExit)          clrReq_d   = NUM_CH'(1) << winner_q;
  end

  assign bus_io.hrq           = hrq_q;
  assign bus_io.validDreq     = grantVec_q;
  assign bus_io.dack          = grantVec_q ^ {NUM_CH{~bus_io.commandReg[7]}};
  assign bus_io.activeChannel = winner_q;
  assign bus_io.clrReq        = clrReq_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter: each scenario task drives vectors and checks hand-derived values.
// Rotation expectations follow DMA_ROTATE_PRIORITY_EN as compiled.
module tb_dma_priority_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;

  dma_priority_arbiter_if bus();

  dma_priority_arbiter #(.NUM_CH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idleInputs;
    bus.dreq = 4'b0000; bus.hlda = 1'b0; bus.eopN = 1'b1; bus.cycleDone = 1'b0;
    bus.commandReg = 8'h00; bus.maskReg = 4'b0000; bus.requestReg = 4'b0000; bus.modeSel = 8'h00;
  endtask

  // Ends any grant via EOP and parks the DUT back in IDLE with no pending requests.
  task automatic endGrant;
    bus.dreq = {4{bus.commandReg[6]}}; bus.requestReg = 4'b0000; bus.maskReg = 4'b0000;
    bus.eopN = 1'b0;
    step();
    bus.eopN = 1'b1; bus.hlda = 1'b0;
    step(2);
  endtask

  task automatic test_reset;
    idleInputs();
    rst_n = 1'b0;
    step(2);
    compared++; if (bus.hrq !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_hrq got %b want 0", bus.hrq); end
    compared++; if (bus.validDreq !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_valid got %b want 0000", bus.validDreq); end
    compared++; if (bus.dack !== 4'b1111) begin mismatched++; $display("[TB] FAIL reset_dack got %b want 1111", bus.dack); end
    compared++; if (bus.activeChannel !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_active got %0d want 0", bus.activeChannel); end
    compared++; if (bus.clrReq !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_clrreq got %b want 0000", bus.clrReq); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fixed_priority;
    bus.dreq = 4'b1010;
    step();
    compared++; if (bus.hrq !== 1'b0) begin mismatched++; $display("[TB] FAIL fixed_hrq_early got %b want 0", bus.hrq); end
    step();
    compared++; if (bus.hrq !== 1'b1) begin mismatched++; $display("[TB] FAIL fixed_hrq got %b want 1", bus.hrq); end
    bus.hlda = 1'b1;
    step();
    compared++; if (bus.validDreq !== 4'b0010) begin mismatched++; $display("[TB] FAIL fixed_valid got %b want 0010", bus.validDreq); end
    compared++; if (bus.activeChannel !== 2'd1) begin mismatched++; $display("[TB] FAIL fixed_active got %0d want 1", bus.activeChannel); end
    compared++; if (bus.dack !== 4'b1101) begin mismatched++; $display("[TB] FAIL fixed_dack got %b want 1101", bus.dack); end
    endGrant();
  endtask

  task automatic test_rotation;
    logic [3:0] expVec;
    bus.commandReg = 8'h10; bus.modeSel = 8'b01010101; bus.dreq = 4'b1111;
    step(2);
    for (int k = 0; k < 4; k++) begin
`ifdef DMA_ROTATE_PRIORITY_EN
      expVec = 4'b0001 << k;
`else
      expVec = 4'b0001;
`endif
      bus.hlda = 1'b1;
      step();
      compared++; if (bus.validDreq !== expVec) begin mismatched++; $display("[TB] FAIL rot_grant%0d got %b want %b", k, bus.validDreq, expVec); end
      bus.cycleDone = 1'b1;
      step();
      bus.cycleDone = 1'b0; bus.hlda = 1'b0;
      compared++; if (bus.hrq !== 1'b0) begin mismatched++; $display("[TB] FAIL rot_release%0d got %b want 0", k, bus.hrq); end
      step(2);
    end
    bus.hlda = 1'b1;
    step();
    compared++; if (bus.validDreq !== 4'b0001) begin mismatched++; $display("[TB] FAIL rot_wrap got %b want 0001", bus.validDreq); end
    endGrant();
    idleInputs();
    step();
  endtask

  task automatic test_mask_polarity;
    bus.commandReg = 8'h40; bus.maskReg = 4'b0001; bus.dreq = 4'b1110;
    step(3);
    compared++; if (bus.hrq !== 1'b0) begin mismatched++; $display("[TB] FAIL mask_no_hrq got %b want 0", bus.hrq); end
    bus.requestReg = 4'b0100;
    step(2);
    compared++; if (bus.hrq !== 1'b1) begin mismatched++; $display("[TB] FAIL swreq_hrq got %b want 1", bus.hrq); end
    bus.hlda = 1'b1;
    step();
    compared++; if (bus.validDreq !== 4'b0100) begin mismatched++; $display("[TB] FAIL swreq_valid got %b want 0100", bus.validDreq); end
    compared++; if (bus.activeChannel !== 2'd2) begin mismatched++; $display("[TB] FAIL swreq_active got %0d want 2", bus.activeChannel); end
    compared++; if (bus.dack !== 4'b1011) begin mismatched++; $display("[TB] FAIL swreq_dack got %b want 1011", bus.dack); end
    endGrant();
    idleInputs();
    step();
  endtask

  task automatic test_block_mode;
    bus.commandReg = 8'h80; bus.modeSel = 8'b00000010; bus.dreq = 4'b0001;
    step(2);
    bus.hlda = 1'b1;
    step();
    compared++; if (bus.dack !== 4'b0001) begin mismatched++; $display("[TB] FAIL block_dack got %b want 0001", bus.dack); end
    for (int i = 0; i < 3; i++) begin
      step(4);
      bus.cycleDone = 1'b1;
      step();
      bus.cycleDone = 1'b0;
      if (i == 1) bus.maskReg = 4'b0001;
      compared++; if (bus.validDreq !== 4'b0001) begin mismatched++; $display("[TB] FAIL block_hold%0d got %b want 0001", i, bus.validDreq); end
      compared++; if (bus.hrq !== 1'b1) begin mismatched++; $display("[TB] FAIL block_hrq%0d got %b want 1", i, bus.hrq); end
    end
    bus.eopN = 1'b0;
    step();
    bus.eopN = 1'b1;
    compared++; if (bus.hrq !== 1'b0) begin mismatched++; $display("[TB] FAIL block_eop_hrq got %b want 0", bus.hrq); end
    compared++; if (bus.clrReq !== 4'b0001) begin mismatched++; $display("[TB] FAIL block_clrreq got %b want 0001", bus.clrReq); end
    compared++; if (bus.dack !== 4'b0000) begin mismatched++; $display("[TB] FAIL block_eop_dack got %b want 0000", bus.dack); end
    step();
    compared++; if (bus.clrReq !== 4'b0000) begin mismatched++; $display("[TB] FAIL block_clrreq_once got %b want 0000", bus.clrReq); end
    idleInputs();
    step(2);
  endtask

  task automatic test_demand_mode;
    bus.dreq = 4'b0001;
    step(2);
    bus.hlda = 1'b1;
    step();
    step(4);
    bus.cycleDone = 1'b1;
    step();
    bus.cycleDone = 1'b0;
    compared++; if (bus.hrq !== 1'b1) begin mismatched++; $display("[TB] FAIL demand_hold got %b want 1", bus.hrq); end
    bus.dreq = 4'b0000;
    step(4);
    compared++; if (bus.validDreq !== 4'b0001) begin mismatched++; $display("[TB] FAIL demand_wait_done got %b want 0001", bus.validDreq); end
    bus.cycleDone = 1'b1;
    step();
    bus.cycleDone = 1'b0;
    compared++; if (bus.hrq !== 1'b0) begin mismatched++; $display("[TB] FAIL demand_release got %b want 0", bus.hrq); end
    compared++; if (bus.dack !== 4'b1111) begin mismatched++; $display("[TB] FAIL demand_dack got %b want 1111", bus.dack); end
    compared++; if (bus.clrReq !== 4'b0000) begin mismatched++; $display("[TB] FAIL demand_clrreq got %b want 0000", bus.clrReq); end
    bus.hlda = 1'b0;
    step(2);
  endtask

  task automatic test_eop_and_errors;
    bus.modeSel = 8'b00010000; bus.dreq = 4'b0100;
    step(2);
    bus.hlda = 1'b1;
    step();
    bus.eopN = 1'b0; bus.cycleDone = 1'b1;
    step();
    bus.eopN = 1'b1; bus.cycleDone = 1'b0;
    compared++; if (bus.clrReq !== 4'b0100) begin mismatched++; $display("[TB] FAIL eop_done_clrreq got %b want 0100", bus.clrReq); end
    bus.hlda = 1'b0;
    step(2);
    bus.hlda = 1'b1;
    step();
    compared++; if (bus.activeChannel !== 2'd2) begin mismatched++; $display("[TB] FAIL regrant_active got %0d want 2", bus.activeChannel); end
    bus.hlda = 1'b0;
    step();
    compared++; if (bus.hrq !== 1'b0) begin mismatched++; $display("[TB] FAIL hlda_drop_hrq got %b want 0", bus.hrq); end
    compared++; if (bus.clrReq !== 4'b0000) begin mismatched++; $display("[TB] FAIL hlda_drop_clrreq got %b want 0000", bus.clrReq); end
    idleInputs();
    step(2);
  endtask

  task automatic test_withdraw;
    bus.dreq = 4'b0001;
    step(2);
    compared++; if (bus.hrq !== 1'b1) begin mismatched++; $display("[TB] FAIL withdraw_hrq got %b want 1", bus.hrq); end
    bus.dreq = 4'b0000;
    step(2);
    compared++; if (bus.hrq !== 1'b0) begin mismatched++; $display("[TB] FAIL withdraw_drop got %b want 0", bus.hrq); end
    bus.hlda = 1'b1;
    step();
    compared++; if (bus.validDreq !== 4'b0000) begin mismatched++; $display("[TB] FAIL withdraw_valid got %b want 0000", bus.validDreq); end
    compared++; if (bus.dack !== 4'b1111) begin mismatched++; $display("[TB] FAIL withdraw_dack got %b want 1111", bus.dack); end
    bus.hlda = 1'b0;
    step(3);
    compared++; if (bus.hrq !== 1'b0) begin mismatched++; $display("[TB] FAIL withdraw_idle got %b want 0", bus.hrq); end
  endtask

  task automatic test_async_reset;
    bus.dreq = 4'b0001;
    step(2);
    bus.hlda = 1'b1;
    step();
    compared++; if (bus.validDreq !== 4'b0001) begin mismatched++; $display("[TB] FAIL areset_pre got %b want 0001", bus.validDreq); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    compared++; if (bus.hrq !== 1'b0) begin mismatched++; $display("[TB] FAIL areset_hrq got %b want 0", bus.hrq); end
    compared++; if (bus.validDreq !== 4'b0000) begin mismatched++; $display("[TB] FAIL areset_valid got %b want 0000", bus.validDreq); end
    compared++; if (bus.dack !== 4'b1111) begin mismatched++; $display("[TB] FAIL areset_dack got %b want 1111", bus.dack); end
    idleInputs();
    step();
    rst_n = 1'b1;
    step();
    compared++; if (bus.hrq !== 1'b0) begin mismatched++; $display("[TB] FAIL areset_idle got %b want 0", bus.hrq); end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_rotation();
    test_mask_polarity();
    test_block_mode();
    test_demand_mode();
    test_eop_and_errors();
    test_withdraw();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
